// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: issues word fetches to a 1-cycle memory and buffers them toward decode.
// Optional perf counters are compiled in when IFETCH_PERF_CNT_EN is defined.
module ifetch_ctrl #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          TAG_WIDTH  = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_rvalid,
  output logic [TAG_WIDTH-1:0]  mem_rtag,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rvalid_in,
  input  logic [TAG_WIDTH-1:0]  mem_rtag_in,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_flush_cnt,
`endif
  output logic [31:0]           instr_pc
);

  // Handshake: decode takes the head in any cycle where instr_valid && instr_ready,
  // unless redirect_valid is high in that cycle, which flushes the buffer instead.
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]          pc_q;
  logic [31:0]          inflight_pc_q;
  logic                 inflight_q;
  logic [TAG_WIDTH-1:0] epoch_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [PW-1:0]        wr_ptr_q;
  logic [CW-1:0]        count_q;
  logic [31:0]          fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]          fifo_data_q [FIFO_DEPTH];

  logic [CW:0] occ_sum;
  logic        issue;
  logic        push;
  logic        pop;
  logic        head_valid;

  // Reserving a slot for the in-flight word makes overflow impossible.
  assign occ_sum    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue      = rst_n && !redirect_valid && (occ_sum < DEPTH_C);
  assign push       = inflight_q && mem_rvalid_in && (mem_rtag_in == epoch_q) && !redirect_valid;
  assign head_valid = rst_n && (count_q != '0);
  assign pop        = head_valid && instr_ready && !redirect_valid;

  assign mem_rvalid  = issue;
  assign mem_raddr   = issue ? pc_q[ADDR_WIDTH-1:0] : '0;
  assign mem_rtag    = issue ? epoch_q : '0;
  assign instr_valid = head_valid;
  assign instr       = head_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign instr_pc    = head_valid ? fifo_pc_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
      fifo_data_q[wr_ptr_q] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      epoch_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc;
      epoch_q    <= epoch_q + TAG_WIDTH'(1);
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + 32'd4;
        inflight_pc_q <= pc_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (issue && (fetch_cnt_q != 32'hFFFF_FFFF))
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect_valid && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
